// File: rtl/imem_arbiter_if.sv
// Signal bundle between the imem arbiter and its clients: fetch stage,
// program loader and the instruction memory macro.
interface imem_arbiter_if #(
  parameter int ADDR_W = 10
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_gnt;
  logic              fetch_rvalid;
  logic [31:0]       fetch_rdata;
  logic              fetch_err;

  logic              load_active;
  logic              load_req;
  logic [ADDR_W-1:0] load_addr;
  logic [7:0]        load_wdata;
  logic              load_gnt;
  logic [ADDR_W:0]   load_count;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [31:0]       mem_rdata;

  // master: the surrounding system (fetch, loader, memory macro)
  modport master (
    output fetch_req, fetch_addr, load_active, load_req, load_addr, load_wdata, mem_rdata,
    input  fetch_gnt, fetch_rvalid, fetch_rdata, fetch_err, load_gnt, load_count,
           mem_addr, mem_we, mem_wdata
  );

  modport slave (
    input  fetch_req, fetch_addr, load_active, load_req, load_addr, load_wdata, mem_rdata,
    output fetch_gnt, fetch_rvalid, fetch_rdata, fetch_err, load_gnt, load_count,
           mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/imem_arbiter.sv
// Single-port instruction memory arbiter: fetch reads vs loader byte writes,
// load-window gating, bounded fetch starvation and a loaded-byte counter.
module imem_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  imem_arbiter_if.slave bus
);
  localparam logic [3:0]      LIMIT   = 4'(STARVE_LIMIT);
  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  typedef struct packed {
    logic vld;
    logic err;
  } rsp_t;

  rsp_t              rsp_q;
  logic [3:0]        starve_cnt;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              la_q;

  logic              fgnt, lgnt;
  logic              aligned, fetch_rd, la_rise;
  logic [ADDR_W-1:0] addr_mux;

  // Grants are gated by rst_n so nothing reaches memory while in reset.
  always_comb begin
    fgnt = 1'b0;
    lgnt = 1'b0;
    if (rst_n) begin
      if (bus.load_active) begin
        lgnt = bus.load_req;
      end else if (bus.fetch_req && bus.load_req) begin
        fgnt = (starve_cnt == LIMIT);
        lgnt = !fgnt;
      end else begin
        fgnt = bus.fetch_req;
        lgnt = bus.load_req;
      end
    end
  end

  assign aligned  = (bus.fetch_addr[1:0] == 2'b00);
  assign fetch_rd = fgnt && aligned;
  assign la_rise  = bus.load_active && !la_q;
  assign addr_mux = lgnt ? bus.load_addr : (fetch_rd ? bus.fetch_addr : addr_q);

  assign bus.fetch_gnt = fgnt;
  assign bus.load_gnt  = lgnt;
  assign bus.mem_addr  = addr_mux;
  assign bus.mem_we    = lgnt;
  assign bus.mem_wdata = lgnt ? bus.load_wdata : 8'h00;
  assign bus.load_count = cnt_q;

  // A reset asserted while a response is in flight suppresses it immediately.
  assign bus.fetch_rvalid = rsp_q.vld && rst_n;
  assign bus.fetch_err    = bus.fetch_rvalid && rsp_q.err;
  assign bus.fetch_rdata  = (bus.fetch_rvalid && !rsp_q.err) ? bus.mem_rdata : 32'h0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_q      <= '0;
      starve_cnt <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      la_q       <= 1'b0;
    end else begin
      la_q  <= bus.load_active;
      rsp_q <= '{vld: fgnt, err: !aligned};
      if (lgnt || fetch_rd) addr_q <= addr_mux;

      if (bus.load_active || fgnt || !bus.fetch_req)
        starve_cnt <= '0;
      else if (lgnt && starve_cnt != LIMIT)
        starve_cnt <= starve_cnt + 4'd1;

      // The window's first cycle restarts the count, including its own write.
      if (la_rise)
        cnt_q <= lgnt ? {{ADDR_W{1'b0}}, 1'b1} : '0;
      else if (lgnt && bus.load_active && cnt_q != CNT_MAX)
        cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a memory macro model, a per-cycle
// reference model and hand-computed literal checks.
module tb_imem_arbiter;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int SL     = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  imem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  imem_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(SL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Memory macro: registered 4-byte big-endian read, write on the edge.
  logic [7:0] mem [DEPTH];
  logic       loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'(i);
      loaded <= 1'b1;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
    bus.mem_rdata <= {mem[bus.mem_addr], mem[(int'(bus.mem_addr) + 1) % DEPTH],
                      mem[(int'(bus.mem_addr) + 2) % DEPTH], mem[(int'(bus.mem_addr) + 3) % DEPTH]};
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [7:0]  gold [DEPTH];
  int          m_starve = 0;
  int          m_cnt    = 0;
  logic [9:0]  m_hold   = '0;
  logic        m_pv     = 1'b0;
  logic        m_perr   = 1'b0;
  logic [31:0] m_pdata  = '0;
  logic        m_la_prev = 1'b0;

  task automatic model_step();
    logic efg, elg, al;
    logic [9:0] fa;
    int a;
    fa  = bus.fetch_addr;
    al  = (fa[1:0] == 2'b00);
    efg = 1'b0;
    elg = 1'b0;
    if (rst_n) begin
      if (bus.load_active) elg = bus.load_req;
      else if (bus.fetch_req && bus.load_req) begin
        efg = (m_starve == SL);
        elg = !efg;
      end else begin
        efg = bus.fetch_req;
        elg = bus.load_req;
      end
    end
    chk("fetch_gnt", bus.fetch_gnt, efg);
    chk("load_gnt", bus.load_gnt, elg);
    chk("mem_we", bus.mem_we, elg);
    chk("mem_wdata", bus.mem_wdata, elg ? bus.load_wdata : 8'h00);
    if (elg) chk("mem_addr_load", bus.mem_addr, bus.load_addr);
    else if (efg && al) chk("mem_addr_fetch", bus.mem_addr, fa);
    else if (!efg) chk("mem_addr_hold", bus.mem_addr, m_hold);
    chk("fetch_rvalid", bus.fetch_rvalid, m_pv && rst_n);
    if (m_pv && rst_n) begin
      chk("fetch_err", bus.fetch_err, m_perr);
      chk("fetch_rdata", bus.fetch_rdata, m_pdata);
    end
    chk("load_count", bus.load_count, m_cnt);

    if (!rst_n) begin
      m_starve = 0; m_cnt = 0; m_hold = '0; m_pv = 1'b0; m_la_prev = 1'b0;
    end else begin
      a       = int'(fa);
      m_pv    = efg;
      m_perr  = !al;
      m_pdata = al ? {gold[a], gold[(a+1)%DEPTH], gold[(a+2)%DEPTH], gold[(a+3)%DEPTH]} : 32'h0;
      if (elg) begin
        gold[bus.load_addr] = bus.load_wdata;
        m_hold = bus.load_addr;
      end else if (efg && al) begin
        m_hold = fa;
      end
      if (bus.load_active || efg || !bus.fetch_req) m_starve = 0;
      else if (elg && m_starve < SL) m_starve++;
      if (bus.load_active && !m_la_prev) m_cnt = elg ? 1 : 0;
      else if (elg && bus.load_active && m_cnt < DEPTH) m_cnt++;
      m_la_prev = bus.load_active;
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) gold[i] = 8'(i);
    forever begin
      @(negedge clk);
      model_step();
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  logic [11:0] fpat;
  logic [4:0]  fpat2;

  initial begin
    fpat  = 12'b0010_0001_0000;
    fpat2 = 5'b10000;
    rst_n = 1'b0;
    bus.fetch_req   = 1'b1;
    bus.fetch_addr  = 10'h000;
    bus.load_active = 1'b0;
    bus.load_req    = 1'b1;
    bus.load_addr   = 10'h010;
    bus.load_wdata  = 8'h55;

    // Reset with both requests pending
    nxt(); nxt(); neg();
    chk("rst_fetch_gnt", bus.fetch_gnt, 0);
    chk("rst_load_gnt", bus.load_gnt, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_rvalid", bus.fetch_rvalid, 0);
    chk("rst_rdata", bus.fetch_rdata, 0);
    chk("rst_err", bus.fetch_err, 0);
    chk("rst_count", bus.load_count, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    nxt(); rst_n = 1'b1; neg();
    chk("first_load_gnt", bus.load_gnt, 1);
    chk("first_fetch_gnt", bus.fetch_gnt, 0);

    // Back-to-back aligned fetches
    nxt(); bus.load_req = 1'b0; bus.fetch_addr = 10'h000; neg();
    chk("f0_gnt", bus.fetch_gnt, 1);
    nxt(); bus.fetch_addr = 10'h004; neg();
    chk("f0_rvalid", bus.fetch_rvalid, 1);
    chk("f0_rdata", bus.fetch_rdata, 32'h00010203);
    nxt(); bus.fetch_req = 1'b0; neg();
    chk("f4_rvalid", bus.fetch_rvalid, 1);
    chk("f4_rdata", bus.fetch_rdata, 32'h04050607);

    // Misaligned fetch
    nxt(); bus.fetch_req = 1'b1; bus.fetch_addr = 10'h006; neg();
    chk("mis_gnt", bus.fetch_gnt, 1);
    chk("mis_we", bus.mem_we, 0);
    nxt(); bus.fetch_req = 1'b0; neg();
    chk("mis_rvalid", bus.fetch_rvalid, 1);
    chk("mis_err", bus.fetch_err, 1);
    chk("mis_rdata", bus.fetch_rdata, 0);

    // Starvation bound: LLLLF repeating
    nxt(); bus.fetch_req = 1'b1; bus.fetch_addr = 10'h020; bus.load_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.load_addr  = 10'(10'h100 + i);
      bus.load_wdata = 8'(i);
      neg();
      chk("starve_pat", bus.fetch_gnt, fpat[i]);
      nxt();
    end

    // Load window: write, idle-loader blocking, then read back
    bus.load_active = 1'b1; bus.load_addr = 10'h008; bus.load_wdata = 8'hAA;
    bus.fetch_addr = 10'h008; neg();
    chk("win_load_gnt", bus.load_gnt, 1);
    chk("win_fetch_blk", bus.fetch_gnt, 0);
    nxt(); bus.load_req = 1'b0; neg();
    chk("win_idle_blk", bus.fetch_gnt, 0);
    nxt(); bus.load_active = 1'b0; neg();
    chk("win_fetch_gnt", bus.fetch_gnt, 1);
    chk("win_count", bus.load_count, 1);
    nxt(); bus.fetch_req = 1'b0; neg();
    chk("raw_rdata", bus.fetch_rdata, 32'hAA090A0B);

    // Highest legal fetch address
    nxt(); bus.fetch_req = 1'b1; bus.fetch_addr = 10'h3FC; neg();
    nxt(); bus.fetch_req = 1'b0; neg();
    chk("top_rdata", bus.fetch_rdata, 32'hFCFDFEFF);

    // Reset the cycle after a fetch grant drops the response
    nxt(); bus.fetch_req = 1'b1; bus.fetch_addr = 10'h000; neg();
    nxt(); bus.fetch_req = 1'b0; rst_n = 1'b0; neg();
    chk("rstmid_rvalid", bus.fetch_rvalid, 0);
    nxt(); rst_n = 1'b1; neg();
    chk("rstmid_rvalid2", bus.fetch_rvalid, 0);
    chk("rstmid_count", bus.load_count, 0);

    // Reset clears a partially built starvation count
    nxt(); bus.fetch_req = 1'b1; bus.fetch_addr = 10'h020; bus.load_req = 1'b1;
    bus.load_addr = 10'h200;
    repeat (3) begin neg(); nxt(); end
    rst_n = 1'b0; neg();
    nxt(); rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      neg();
      chk("rst_starve_pat", bus.fetch_gnt, fpat2[i]);
      nxt();
    end

    // load_count saturation
    bus.fetch_req = 1'b0; bus.load_active = 1'b1; bus.load_req = 1'b1;
    for (int i = 0; i < 1030; i++) begin
      bus.load_addr  = 10'(i);
      bus.load_wdata = 8'(i ^ 8'h5A);
      nxt();
    end
    bus.load_req = 1'b0; neg();
    chk("count_sat", bus.load_count, 1024);
    nxt(); bus.load_active = 1'b0;
    nxt(); nxt();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
